// File: rtl/adc_frame_reader.sv
// adc_frame_reader: waits until all four channel FIFOs hold a sample, pops
// them together, sign-extends the 24-bit samples and presents one aligned
// frame with a sequence number on a valid/ready interface. A skew monitor
// flags channel FIFOs that stay out of step while the reader is idle.
module adc_frame_reader #(
  parameter int SAMPLE_MSB   = 31,
  parameter int SAMPLE_W     = 24,
  parameter int SKEW_TIMEOUT = 64,
  parameter int SEQ_W        = 16
) (
  input  logic                    system_clock,
  input  logic                    reset_n,
  input  logic [3:0]              fifo_rdempty,
  input  logic [31:0]             fifo_q0,
  input  logic [31:0]             fifo_q1,
  input  logic [31:0]             fifo_q2,
  input  logic [31:0]             fifo_q3,
  output logic [3:0]              fifo_rdreq,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic signed [31:0]      ch0,
  output logic signed [31:0]      ch1,
  output logic signed [31:0]      ch2,
  output logic signed [31:0]      ch3,
  output logic [SEQ_W-1:0]        frame_seq,
  output logic                    desync_err,
  output logic [2:0]              state
);

  localparam int SKEW_CW = $clog2(SKEW_TIMEOUT + 1);
  localparam logic [SKEW_CW-1:0] SKEW_MAX  = SKEW_CW'(SKEW_TIMEOUT);
  localparam logic [SKEW_CW-1:0] SKEW_LAST = SKEW_CW'(SKEW_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    CAPTURE = 3'd2,
    PRESENT = 3'd3
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic                 capture_en;
  logic                 handshake;
  logic                 all_ready;
  logic                 partial;
  logic [SKEW_CW-1:0]   skew_cnt;
  logic                 unused_raw_bits;

  // Pull the sample field out of a raw FIFO word and sign-extend it to 32 bits.
  function automatic logic signed [31:0] sext_sample(input logic [31:0] raw);
    logic signed [SAMPLE_W-1:0] s;
    s = raw[SAMPLE_MSB -: SAMPLE_W];
    return {{(32-SAMPLE_W){s[SAMPLE_W-1]}}, s};
  endfunction

  assign all_ready = (fifo_rdempty == 4'b0000);
  assign partial   = (fifo_rdempty != 4'b0000) && (fifo_rdempty != 4'b1111);
  assign handshake = frame_valid & frame_ready;
  assign state     = state_q;
  // Bits outside the sample field are deliberately ignored.
  assign unused_raw_bits = ^{fifo_q0, fifo_q1, fifo_q2, fifo_q3};

  // FSM state register.
  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state and read-request decode; the read is re-qualified on empty flags
  // so a FIFO that is empty at the read cycle is never popped.
  always_comb begin
    state_d    = state_q;
    fifo_rdreq = 4'b0000;
    capture_en = 1'b0;
    case (state_q)
      IDLE:    if (all_ready) state_d = READ;
      READ: begin
        if (all_ready) begin
          fifo_rdreq = 4'b1111;
          state_d    = CAPTURE;
        end else begin
          state_d    = IDLE;
        end
      end
      CAPTURE: begin
        capture_en = 1'b1;
        state_d    = PRESENT;
      end
      PRESENT: if (frame_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Frame registers: capture one cycle after the pop, hold until handshake.
  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      ch0         <= '0;
      ch1         <= '0;
      ch2         <= '0;
      ch3         <= '0;
      frame_valid <= 1'b0;
      frame_seq   <= '0;
    end else if (capture_en) begin
      ch0         <= sext_sample(fifo_q0);
      ch1         <= sext_sample(fifo_q1);
      ch2         <= sext_sample(fifo_q2);
      ch3         <= sext_sample(fifo_q3);
      frame_valid <= 1'b1;
    end else if (handshake) begin
      frame_valid <= 1'b0;
      frame_seq   <= frame_seq + 1'b1;
    end
  end

  // Skew monitor: count idle cycles with some but not all FIFOs empty.
  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      skew_cnt   <= '0;
      desync_err <= 1'b0;
    end else if ((state_q == IDLE) && partial) begin
      if (skew_cnt != SKEW_MAX)  skew_cnt   <= skew_cnt + 1'b1;
      if (skew_cnt == SKEW_LAST) desync_err <= 1'b1;
    end else begin
      skew_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_adc_frame_reader.sv
// Testbench for adc_frame_reader: table-driven frames, hand-written latency,
// backpressure, skew, reset and wrap sequences, then randomized FIFO traffic
// checked against a queue-based reference of per-channel sample order.
module tb_adc_frame_reader;

  logic               system_clock = 1'b0;
  logic               reset_n;
  logic [3:0]         fifo_rdempty;
  logic [31:0]        fifo_q0, fifo_q1, fifo_q2, fifo_q3;
  logic               frame_ready;
  logic [3:0]         fifo_rdreq;
  logic               frame_valid;
  logic [31:0]        ch0, ch1, ch2, ch3;
  logic [15:0]        frame_seq;
  logic               desync_err;
  logic [2:0]         state;

  logic [3:0]         w_rdreq;
  logic               w_fv;
  logic [31:0]        w_ch0, w_ch1, w_ch2, w_ch3;
  logic [3:0]         w_seq;
  logic               w_desync;
  logic [2:0]         w_state;

  always #10 system_clock = ~system_clock;

  adc_frame_reader dut (
    .system_clock(system_clock), .reset_n(reset_n), .fifo_rdempty(fifo_rdempty),
    .fifo_q0(fifo_q0), .fifo_q1(fifo_q1), .fifo_q2(fifo_q2), .fifo_q3(fifo_q3),
    .fifo_rdreq(fifo_rdreq), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .ch0(ch0), .ch1(ch1), .ch2(ch2), .ch3(ch3), .frame_seq(frame_seq),
    .desync_err(desync_err), .state(state)
  );

  // Narrow-sequence build so the wrap is reachable in a short run.
  adc_frame_reader #(.SEQ_W(4)) dut_w (
    .system_clock(system_clock), .reset_n(reset_n), .fifo_rdempty(fifo_rdempty),
    .fifo_q0(fifo_q0), .fifo_q1(fifo_q1), .fifo_q2(fifo_q2), .fifo_q3(fifo_q3),
    .fifo_rdreq(w_rdreq), .frame_valid(w_fv), .frame_ready(frame_ready),
    .ch0(w_ch0), .ch1(w_ch1), .ch2(w_ch2), .ch3(w_ch3), .frame_seq(w_seq),
    .desync_err(w_desync), .state(w_state)
  );

  typedef struct packed {
    logic [31:0] q0, q1, q2, q3;
    logic [31:0] e0, e1, e2, e3;
  } vec_t;

  int nvec = 0;
  int nerr = 0;
  int rd_cnt = 0;
  int illegal = 0;
  int w_diff = 0;
  int hs_cnt = 0;
  bit model_on = 0;
  bit push_en = 0;
  bit rand_ready = 0;
  logic [15:0] exp_seq;
  logic [31:0] fq0[$], fq1[$], fq2[$], fq3[$];
  logic [31:0] exq0[$], exq1[$], exq2[$], exq3[$];
  int push_tot[4];

  // Reference sample extraction: top 24 bits of the word as a signed number.
  function automatic logic [31:0] ref_sext(input logic [31:0] w);
    return $signed(w) >>> 8;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic push_rand();
    logic [31:0] w;
    if ($urandom_range(2) == 0 && fq0.size() < 8) begin
      w = $urandom; fq0.push_back(w); exq0.push_back(w); push_tot[0]++;
    end
    if ($urandom_range(2) == 0 && fq1.size() < 8) begin
      w = $urandom; fq1.push_back(w); exq1.push_back(w); push_tot[1]++;
    end
    if ($urandom_range(2) == 0 && fq2.size() < 8) begin
      w = $urandom; fq2.push_back(w); exq2.push_back(w); push_tot[2]++;
    end
    if ($urandom_range(2) == 0 && fq3.size() < 8) begin
      w = $urandom; fq3.push_back(w); exq3.push_back(w); push_tot[3]++;
    end
  endtask

  // One clock: sample at the falling edge, then update the FIFO model after the rising edge.
  task automatic tick();
    logic [3:0] rq;
    logic       hs;
    @(negedge system_clock);
    rq = fifo_rdreq;
    hs = frame_valid & frame_ready;
    if (rq !== 4'h0 && rq !== 4'hF) illegal++;
    if (rq !== 4'h0 && fifo_rdempty !== 4'h0) illegal++;
    if (rq === 4'hF) rd_cnt++;
    if ({w_rdreq, w_fv, w_ch0, w_ch1, w_ch2, w_ch3, w_desync, w_state} !==
        {fifo_rdreq, frame_valid, ch0, ch1, ch2, ch3, desync_err, state}) w_diff++;
    if (hs) hs_cnt++;
    if (model_on && hs) begin
      if (exq0.size() == 0 || exq1.size() == 0 || exq2.size() == 0 || exq3.size() == 0) begin
        chk("sb_frame_avail", 32'd0, 32'd1);
      end else begin
        chk("sb_ch0", ch0, ref_sext(exq0.pop_front()));
        chk("sb_ch1", ch1, ref_sext(exq1.pop_front()));
        chk("sb_ch2", ch2, ref_sext(exq2.pop_front()));
        chk("sb_ch3", ch3, ref_sext(exq3.pop_front()));
        chk("sb_seq", {16'd0, frame_seq}, {16'd0, exp_seq});
      end
      exp_seq++;
    end
    @(posedge system_clock);
    #1;
    if (model_on) begin
      if (rq === 4'hF) begin
        if (fq0.size() == 0 || fq1.size() == 0 || fq2.size() == 0 || fq3.size() == 0) illegal++;
        else begin
          fifo_q0 = fq0.pop_front();
          fifo_q1 = fq1.pop_front();
          fifo_q2 = fq2.pop_front();
          fifo_q3 = fq3.pop_front();
        end
      end
      if (push_en) push_rand();
      fifo_rdempty = {fq3.size() == 0, fq2.size() == 0, fq1.size() == 0, fq0.size() == 0};
      if (rand_ready) frame_ready = $urandom_range(1);
    end
  endtask

  task automatic wait_fv(input int lim);
    int n;
    n = 0;
    while (frame_valid !== 1'b1 && n < lim) begin
      tick();
      n++;
    end
    chk("fv_wait", {31'd0, frame_valid}, 32'd1);
  endtask

  // Single frame from IDLE: FIFOs non-empty for the read, empty afterwards.
  task automatic direct_frame(input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] c, input logic [31:0] d);
    fifo_q0 = a; fifo_q1 = b; fifo_q2 = c; fifo_q3 = d;
    fifo_rdempty = 4'h0;
    tick();
    tick();
    fifo_rdempty = 4'hF;
    wait_fv(4);
  endtask

  vec_t tbl[3];
  logic [31:0] h0, h1, h2, h3;
  logic [15:0] hseq;
  int unstable;
  int n;
  int fv_seen;
  int min_push;

  initial begin
    tbl[0] = '{32'h7FFFFF00, 32'h80000000, 32'hFFFFFF00, 32'h00000100,
               32'h007FFFFF, 32'hFF800000, 32'hFFFFFFFF, 32'h00000001};
    tbl[1] = '{32'h000000FF, 32'h123456AB, 32'h800001CD, 32'hFFFFFFFF,
               32'h00000000, 32'h00123456, 32'hFF800001, 32'hFFFFFFFF};
    tbl[2] = '{32'h7FFFFFFF, 32'h00000000, 32'hA5A5A5A5, 32'h5A5A5A5A,
               32'h007FFFFF, 32'h00000000, 32'hFFA5A5A5, 32'h005A5A5A};

    // Reset and idle with empty FIFOs.
    reset_n = 1'b0; fifo_rdempty = 4'hF; frame_ready = 1'b0;
    fifo_q0 = '0; fifo_q1 = '0; fifo_q2 = '0; fifo_q3 = '0;
    repeat (3) @(posedge system_clock);
    #1;
    chk("rst_rdreq", {28'd0, fifo_rdreq}, 32'd0);
    chk("rst_fv", {31'd0, frame_valid}, 32'd0);
    chk("rst_ch0", ch0, 32'd0);
    chk("rst_ch3", ch3, 32'd0);
    chk("rst_seq", {16'd0, frame_seq}, 32'd0);
    chk("rst_desync", {31'd0, desync_err}, 32'd0);
    chk("rst_state", {29'd0, state}, 32'd0);
    reset_n = 1'b1;
    rd_cnt = 0; fv_seen = 0;
    repeat (100) begin
      tick();
      if (frame_valid !== 1'b0) fv_seen++;
    end
    chk("idle_rdreq_cnt", rd_cnt, 0);
    chk("idle_fv_cnt", fv_seen, 0);
    chk("idle_desync", {31'd0, desync_err}, 32'd0);

    // Latency and alignment of the first frame.
    fifo_q0 = 32'h7FFFFF00; fifo_q1 = 32'h80000000;
    fifo_q2 = 32'hFFFFFF00; fifo_q3 = 32'h00000100;
    fifo_rdempty = 4'h0; frame_ready = 1'b1; rd_cnt = 0;
    chk("lat_T_rdreq", {28'd0, fifo_rdreq}, 32'd0);
    tick();
    chk("lat_T1_rdreq", {28'd0, fifo_rdreq}, 32'hF);
    chk("lat_T1_fv", {31'd0, frame_valid}, 32'd0);
    tick();
    chk("lat_T2_rdreq", {28'd0, fifo_rdreq}, 32'd0);
    chk("lat_T2_fv", {31'd0, frame_valid}, 32'd0);
    fifo_rdempty = 4'hF;
    tick();
    chk("lat_T3_fv", {31'd0, frame_valid}, 32'd1);
    chk("lat_ch0", ch0, 32'h007FFFFF);
    chk("lat_ch1", ch1, 32'hFF800000);
    chk("lat_ch2", ch2, 32'hFFFFFFFF);
    chk("lat_ch3", ch3, 32'h00000001);
    chk("lat_seq", {16'd0, frame_seq}, 32'd0);
    tick();
    chk("lat_T4_fv", {31'd0, frame_valid}, 32'd0);
    chk("lat_T4_seq", {16'd0, frame_seq}, 32'd1);
    chk("lat_rd_cnt", rd_cnt, 1);

    // Backpressure with FIFOs staying non-empty.
    frame_ready = 1'b0;
    fifo_q0 = 32'h12345600; fifo_q1 = 32'hFEDCBA00; fifo_q2 = 32'h00000100; fifo_q3 = 32'h80000100;
    fifo_rdempty = 4'h0;
    wait_fv(6);
    h0 = ch0; h1 = ch1; h2 = ch2; h3 = ch3; hseq = frame_seq;
    rd_cnt = 0; unstable = 0;
    repeat (20) begin
      tick();
      if ({ch0, ch1, ch2, ch3, frame_seq, frame_valid} !== {h0, h1, h2, h3, hseq, 1'b1}) unstable++;
    end
    chk("bp_stable", unstable, 0);
    chk("bp_no_rdreq", rd_cnt, 0);
    chk("bp_ch1", ch1, 32'hFFFEDCBA);
    hs_cnt = 0;
    frame_ready = 1'b1;
    tick();
    fifo_rdempty = 4'hF;
    frame_ready = 1'b0;
    chk("bp_fv_drop", {31'd0, frame_valid}, 32'd0);
    chk("bp_seq", {16'd0, frame_seq}, 32'd2);
    repeat (4) tick();
    chk("bp_one_hs", hs_cnt, 1);
    chk("bp_no_reread", rd_cnt, 0);

    // Table of sign-extension vectors.
    exp_seq = 16'd2;
    for (int i = 0; i < 3; i++) begin
      direct_frame(tbl[i].q0, tbl[i].q1, tbl[i].q2, tbl[i].q3);
      chk($sformatf("tbl%0d_ch0", i), ch0, tbl[i].e0);
      chk($sformatf("tbl%0d_ch1", i), ch1, tbl[i].e1);
      chk($sformatf("tbl%0d_ch2", i), ch2, tbl[i].e2);
      chk($sformatf("tbl%0d_ch3", i), ch3, tbl[i].e3);
      chk($sformatf("tbl%0d_seq", i), {16'd0, frame_seq}, {16'd0, exp_seq});
      frame_ready = 1'b1;
      tick();
      frame_ready = 1'b0;
      exp_seq++;
    end

    // Skew: one FIFO empty for SKEW_TIMEOUT idle cycles.
    fifo_rdempty = 4'b1000; rd_cnt = 0;
    repeat (63) tick();
    chk("skew_63", {31'd0, desync_err}, 32'd0);
    tick();
    chk("skew_64", {31'd0, desync_err}, 32'd1);
    repeat (10) tick();
    chk("skew_sticky", {31'd0, desync_err}, 32'd1);
    chk("skew_no_rdreq", rd_cnt, 0);
    direct_frame(32'h00000500, 32'h00000600, 32'h00000700, 32'h00000800);
    chk("skew_frame_ch3", ch3, 32'h00000008);
    chk("skew_frame_seq", {16'd0, frame_seq}, {16'd0, exp_seq});
    chk("skew_err_kept", {31'd0, desync_err}, 32'd1);
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;

    // Reset while a frame is being presented.
    direct_frame(32'h11111100, 32'h22222200, 32'h33333300, 32'h44444400);
    chk("prst_fv", {31'd0, frame_valid}, 32'd1);
    reset_n = 1'b0;
    #2;
    chk("arst_fv", {31'd0, frame_valid}, 32'd0);
    chk("arst_ch0", ch0, 32'd0);
    chk("arst_ch2", ch2, 32'd0);
    chk("arst_seq", {16'd0, frame_seq}, 32'd0);
    chk("arst_desync", {31'd0, desync_err}, 32'd0);
    chk("arst_state", {29'd0, state}, 32'd0);
    chk("arst_rdreq", {28'd0, fifo_rdreq}, 32'd0);
    tick();
    reset_n = 1'b1;
    direct_frame(32'hFFFFFE00, 32'h00000200, 32'h00000300, 32'h00000400);
    chk("arst_next_seq", {16'd0, frame_seq}, 32'd0);
    chk("arst_next_ch0", ch0, 32'hFFFFFFFE);
    frame_ready = 1'b1;
    tick();

    // Back-to-back frames with full FIFOs, then the 4-bit sequence wrap.
    hs_cnt = 0; n = 0;
    fifo_rdempty = 4'h0;
    while (hs_cnt < 14 && n < 200) begin
      tick();
      n++;
    end
    fifo_rdempty = 4'hF;
    frame_ready = 1'b0;
    chk("thru_cycles", n, 56);
    chk("wrap_pre_w", {28'd0, w_seq}, 32'd15);
    chk("wrap_pre", {16'd0, frame_seq}, 32'd15);
    direct_frame(32'h00000100, 32'h00000100, 32'h00000100, 32'h00000100);
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    chk("wrap_w", {28'd0, w_seq}, 32'd0);
    chk("wrap_full", {16'd0, frame_seq}, 32'd16);

    // Randomized FIFO traffic against the reference queues.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    fifo_rdempty = 4'hF;
    exp_seq = '0; hs_cnt = 0;
    for (int c = 0; c < 4; c++) push_tot[c] = 0;
    model_on = 1; push_en = 1; rand_ready = 1;
    repeat (800) tick();
    push_en = 0; rand_ready = 0; frame_ready = 1'b1;
    repeat (60) tick();
    model_on = 0;
    min_push = push_tot[0];
    for (int c = 1; c < 4; c++) if (push_tot[c] < min_push) min_push = push_tot[c];
    chk("rand_frames", hs_cnt, min_push);

    chk("rdreq_legal", illegal, 0);
    chk("twin_agree", w_diff, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
